avl_board_writer: RTL and testbench

- Avalon-MM master that pushes POLYTRIS board state into the on-chip memory of the VGA board/text display slave.
- Game logic issues row-update or clear-board commands through a valid/ready handshake.
- The block packs each row of 10 four-bit cell colour IDs into two 32-bit words and performs the Avalon writes, honouring waitrequest.
- Sits between the game FSM and the display slave's Avalon-MM port, as a second master beside the NIOS.

---
 rtl/avl_board_writer.sv | 134 +++++++++++++
 tb/tb_avl_board_writer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_board_writer.sv
// Avalon-MM write master that copies POLYTRIS board rows (10 x 4-bit colour IDs)
// into the display slave's memory, two words per row, plus a whole-board clear.
module avl_board_writer #(
  parameter int BASE_ADDR  = 0,
  parameter int BOARD_ROWS = 20,
  parameter int ADDR_W     = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_OP,
  input  logic [4:0]        CMD_ROW,
  input  logic [39:0]       CMD_CELLS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic              AVM_WRITE,
  output logic              AVM_READ,
  output logic              AVM_CS,
  output logic [3:0]        AVM_BYTE_EN,
  output logic [31:0]       AVM_WRITEDATA,
  input  logic              AVM_WAITREQUEST
);

  localparam int CLR_WORDS = 2 * BOARD_ROWS;
  localparam int CNT_W     = $clog2(CLR_WORDS + 1);

  typedef enum logic [1:0] {IDLE, ROW_W0, ROW_W1, CLR} state_t;

  state_t            state, state_nxt;
  logic [4:0]        row_q, row_nxt;
  logic [39:0]       cells_q, cells_nxt;
  logic [CNT_W-1:0]  k_q, k_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              accept;
  logic              xfer_ok;
  logic [ADDR_W-1:0] row_addr;

  assign CMD_READY = RESET && (state == IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign xfer_ok   = !AVM_WAITREQUEST;
  assign row_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({row_q, 1'b0});

  assign BUSY     = (state != IDLE);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign AVM_CS   = AVM_WRITE;
  assign AVM_READ = 1'b0;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= IDLE;
      row_q   <= '0;
      cells_q <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_nxt;
      cells_q <= cells_nxt;
      k_q     <= k_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // Bus signals decode straight from the state, so a stalled transfer holds by construction.
  always_comb begin
    state_nxt     = state;
    row_nxt       = row_q;
    cells_nxt     = cells_q;
    k_nxt         = k_q;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    AVM_ADDR      = '0;
    AVM_WRITE     = 1'b0;
    AVM_BYTE_EN   = 4'h0;
    AVM_WRITEDATA = 32'h0;

    case (state)
      IDLE: begin
        if (accept) begin
          row_nxt   = CMD_ROW;
          cells_nxt = CMD_CELLS;
          k_nxt     = '0;
          if (CMD_OP)
            state_nxt = CLR;
          else if (32'(CMD_ROW) >= BOARD_ROWS)
            err_nxt = 1'b1;
          else
            state_nxt = ROW_W0;
        end
      end
      ROW_W0: begin
        AVM_ADDR      = row_addr;
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = cells_q[31:0];
        if (xfer_ok)
          state_nxt = ROW_W1;
      end
      ROW_W1: begin
        AVM_ADDR      = row_addr + ADDR_W'(1);
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'b0001;
        AVM_WRITEDATA = {24'h0, cells_q[39:32]};
        if (xfer_ok) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      CLR: begin
        AVM_ADDR      = ADDR_W'(BASE_ADDR) + ADDR_W'(k_q);
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = 32'h0;
        if (xfer_ok) begin
          if (k_q == CNT_W'(CLR_WORDS - 1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            k_nxt = k_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avl_board_writer.sv
// Self-checking bench for avl_board_writer: constant vector table, hand-written
// corner sequences, and random commands checked against a write-list model.
module tb_avl_board_writer;

  localparam int BASE = 'h100;
  localparam int ROWS = 20;
  localparam int AW   = 12;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_OP = 1'b0;
  logic [4:0]    CMD_ROW = '0;
  logic [39:0]   CMD_CELLS = '0;
  logic          AVM_WAITREQUEST = 1'b0;
  logic          CMD_READY, BUSY, DONE, ERR;
  logic [AW-1:0] AVM_ADDR;
  logic          AVM_WRITE, AVM_READ, AVM_CS;
  logic [3:0]    AVM_BYTE_EN;
  logic [31:0]   AVM_WRITEDATA;

  avl_board_writer #(.BASE_ADDR(BASE), .BOARD_ROWS(ROWS), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ROW(CMD_ROW), .CMD_CELLS(CMD_CELLS),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .AVM_ADDR(AVM_ADDR), .AVM_WRITE(AVM_WRITE), .AVM_READ(AVM_READ),
    .AVM_CS(AVM_CS), .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic        op;
    logic [4:0]  row;
    logic [39:0] cells;
    int          waitPct;
    logic        expErr;
    int          expNum;
    wr_t         first;
    wr_t         last;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  wr_t  obsQ[$];
  wr_t  expQ[$];
  logic expErr;
  int   doneCycle, errCycle, writeCycles, stalls;
  logic readyAtErr;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference: the list of Avalon writes a command must produce, straight from the command rules.
  task automatic buildModel(input logic op, input logic [4:0] row, input logic [39:0] cells);
    wr_t w;
    expQ.delete();
    expErr = 1'b0;
    if (op) begin
      for (int k = 0; k < 2 * ROWS; k++) begin
        w.addr = 12'(BASE + k);
        w.data = 32'h0;
        w.be   = 4'hF;
        expQ.push_back(w);
      end
    end else if (int'(row) >= ROWS) begin
      expErr = 1'b1;
    end else begin
      w.addr = 12'(BASE + 2 * int'(row));
      w.data = cells[31:0];
      w.be   = 4'hF;
      expQ.push_back(w);
      w.addr = 12'(BASE + 2 * int'(row) + 1);
      w.data = {24'h0, cells[39:32]};
      w.be   = 4'h1;
      expQ.push_back(w);
    end
  endtask

  // Presents one command, then watches the bus until DONE (or a few cycles past ERR).
  task automatic applyStimulus(input logic op, input logic [4:0] row, input logic [39:0] cells,
                               input int waitPct, input logic [63:0] mask);
    logic prevStall;
    wr_t  prevWr;
    wr_t  cur;
    logic fin;
    CMD_VALID = 1'b1;
    CMD_OP = op;
    CMD_ROW = row;
    CMD_CELLS = cells;
    AVM_WAITREQUEST = 1'b0;
    obsQ.delete();
    doneCycle = 0;
    errCycle = 0;
    writeCycles = 0;
    stalls = 0;
    readyAtErr = 1'b0;
    prevStall = 1'b0;
    prevWr = '0;
    fin = 1'b0;
    @(negedge CLK);
    check("accept_ready", 64'(CMD_READY), 64'(1));
    nextCycle();
    CMD_VALID = 1'b0;
    CMD_OP = 1'($urandom);
    CMD_ROW = 5'($urandom);
    CMD_CELLS = {8'($urandom), $urandom};
    for (int c = 1; c <= 400 && !fin; c++) begin
      AVM_WAITREQUEST = (c < 64 && mask[c[5:0]]) || ($urandom_range(99) < waitPct);
      @(negedge CLK);
      check("cs_eq_write", 64'(AVM_CS), 64'(AVM_WRITE));
      check("read_zero", 64'(AVM_READ), 64'(0));
      check("done_err_excl", 64'(DONE && ERR), 64'(0));
      cur = {AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN};
      if (prevStall)
        check("hold_stable", 64'({AVM_WRITE, cur}), 64'({1'b1, prevWr}));
      if (AVM_WRITE) begin
        writeCycles++;
        check("busy_in_write", 64'(BUSY), 64'(1));
        if (AVM_WAITREQUEST) stalls++;
        else obsQ.push_back(cur);
      end
      prevStall = AVM_WRITE && AVM_WAITREQUEST;
      prevWr = cur;
      if (ERR && errCycle == 0) begin
        errCycle = c;
        readyAtErr = CMD_READY;
      end
      if (DONE) begin
        doneCycle = c;
        check("done_busy", 64'(BUSY), 64'(0));
        check("done_ready", 64'(CMD_READY), 64'(1));
        fin = 1'b1;
      end
      if (errCycle != 0 && c >= 3) fin = 1'b1;
      nextCycle();
    end
    AVM_WAITREQUEST = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_timeout actual=no_done_or_err expected=completion op=%0d row=%0d", op, row);
    end
  endtask

  task automatic checkTiming(input string tag, input logic eErr, input int eNum);
    if (eErr) begin
      check({tag, " err_cycle"}, 64'(errCycle), 64'(1));
      check({tag, " no_done"}, 64'(doneCycle), 64'(0));
      check({tag, " no_writes"}, 64'(writeCycles), 64'(0));
      check({tag, " ready_at_err"}, 64'(readyAtErr), 64'(1));
    end else begin
      check({tag, " no_err"}, 64'(errCycle), 64'(0));
      check({tag, " write_cycles"}, 64'(writeCycles), 64'(eNum + stalls));
      check({tag, " done_cycle"}, 64'(doneCycle), 64'(eNum + stalls + 1));
    end
  endtask

  task automatic checkOutput(input string tag);
    checkTiming(tag, expErr, expQ.size());
    check({tag, " num_writes"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      check($sformatf("%s write[%0d]", tag, i), 64'(obsQ[i]), 64'(expQ[i]));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 5'd3,  40'hA976543210, 0,  1'b0, 2,
                {12'h106, 32'h76543210, 4'hF}, {12'h107, 32'h000000A9, 4'h1}};
    vecs[1] = '{1'b0, 5'd19, 40'hFF01234567, 0,  1'b0, 2,
                {12'h126, 32'h01234567, 4'hF}, {12'h127, 32'h000000FF, 4'h1}};
    vecs[2] = '{1'b0, 5'd0,  40'h5ADEADBEEF, 0,  1'b0, 2,
                {12'h100, 32'hDEADBEEF, 4'hF}, {12'h101, 32'h0000005A, 4'h1}};
    vecs[3] = '{1'b0, 5'd20, 40'h1111111111, 0,  1'b1, 0, 48'h0, 48'h0};
    vecs[4] = '{1'b0, 5'd31, 40'h2222222222, 20, 1'b1, 0, 48'h0, 48'h0};
    vecs[5] = '{1'b1, 5'd0,  40'h0000000000, 0,  1'b0, 40,
                {12'h100, 32'h0, 4'hF}, {12'h127, 32'h0, 4'hF}};
    vecs[6] = '{1'b1, 5'd25, 40'hFFFFFFFFFF, 30, 1'b0, 40,
                {12'h100, 32'h0, 4'hF}, {12'h127, 32'h0, 4'hF}};
    vecs[7] = '{1'b0, 5'd7,  40'h123456789A, 40, 1'b0, 2,
                {12'h10E, 32'h3456789A, 4'hF}, {12'h10F, 32'h00000012, 4'h1}};

    RESET = 1'b0;
    repeat (3) nextCycle();
    @(negedge CLK);
    check("reset_ready", 64'(CMD_READY), 64'(0));
    check("reset_busy", 64'(BUSY), 64'(0));
    check("reset_done_err", 64'({DONE, ERR}), 64'(0));
    check("reset_bus", 64'({AVM_WRITE, AVM_CS, AVM_READ, AVM_ADDR, AVM_BYTE_EN}), 64'(0));
    nextCycle();
    RESET = 1'b1;
    @(negedge CLK);
    check("release_ready", 64'(CMD_READY), 64'(1));
    nextCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].row, vecs[i].cells, vecs[i].waitPct, 64'h0);
      checkTiming($sformatf("vec%0d", i), vecs[i].expErr, vecs[i].expNum);
      check($sformatf("vec%0d count", i), 64'(obsQ.size()), 64'(vecs[i].expNum));
      if (vecs[i].expNum > 0 && obsQ.size() > 0) begin
        check($sformatf("vec%0d first", i), 64'(obsQ[0]), 64'(vecs[i].first));
        check($sformatf("vec%0d last", i), 64'(obsQ[obsQ.size()-1]), 64'(vecs[i].last));
      end
      repeat (i % 3) nextCycle();
    end

    // Word 0 stalled for three cycles: presented four cycles, DONE at cycle 6.
    applyStimulus(1'b0, 5'd3, 40'hA976543210, 0, 64'hE);
    buildModel(1'b0, 5'd3, 40'hA976543210);
    checkOutput("stall3");
    check("stall3 stalls", 64'(stalls), 64'(3));
    check("stall3 done_at", 64'(doneCycle), 64'(6));

    // Reset asserted while word 1 is stalled on the bus.
    CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_ROW = 5'd5; CMD_CELLS = 40'h77_0000_1234;
    nextCycle();
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("rst_mid w0", 64'({AVM_WRITE, AVM_ADDR}), 64'({1'b1, 12'h10A}));
    nextCycle();
    AVM_WAITREQUEST = 1'b1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid w1", 64'({AVM_WRITE, AVM_ADDR, AVM_BYTE_EN}), 64'({1'b1, 12'h10B, 4'h1}));
    nextCycle();
    @(negedge CLK);
    check("rst_mid after", 64'({AVM_WRITE, BUSY, DONE, CMD_READY}), 64'(0));
    nextCycle();
    RESET = 1'b1;
    AVM_WAITREQUEST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_mid idle", 64'({AVM_WRITE, BUSY, DONE, CMD_READY}), 64'(1));
      nextCycle();
    end
    applyStimulus(1'b0, 5'd5, 40'h66AABBCCDD, 0, 64'h0);
    buildModel(1'b0, 5'd5, 40'h66AABBCCDD);
    checkOutput("after_rst");

    // Second command offered in the DONE cycle starts with no idle gap.
    CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_ROW = 5'd2; CMD_CELLS = 40'h1122334455;
    nextCycle();
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("b2b a_w0", 64'({AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}),
          64'({1'b1, 12'h104, 32'h22334455, 4'hF}));
    nextCycle();
    @(negedge CLK);
    check("b2b a_w1", 64'({AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}),
          64'({1'b1, 12'h105, 32'h00000011, 4'h1}));
    nextCycle();
    CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_ROW = 5'd9; CMD_CELLS = 40'hC30BADF00D;
    @(negedge CLK);
    check("b2b a_done", 64'({DONE, CMD_READY, AVM_WRITE}), 64'(3'b110));
    nextCycle();
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("b2b b_w0", 64'({AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}),
          64'({1'b1, 12'h112, 32'h0BADF00D, 4'hF}));
    nextCycle();
    @(negedge CLK);
    check("b2b b_w1", 64'({AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN}),
          64'({1'b1, 12'h113, 32'h000000C3, 4'h1}));
    nextCycle();
    @(negedge CLK);
    check("b2b b_done", 64'({DONE, BUSY, AVM_WRITE}), 64'(3'b100));
    nextCycle();

    for (int i = 0; i < 30; i++) begin
      logic        op;
      logic [4:0]  row;
      logic [39:0] cells;
      int          wp;
      op    = ($urandom_range(5) == 0);
      row   = 5'($urandom_range(31));
      cells = {8'($urandom), $urandom};
      wp    = 15 * int'($urandom_range(3));
      applyStimulus(op, row, cells, wp, 64'h0);
      buildModel(op, row, cells);
      checkOutput($sformatf("rand%0d", i));
      repeat ($urandom_range(2)) nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
